// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key length encoding, round counts,
// S-box table and GF(2^8) helpers.
package aes_pkg;

  typedef enum logic [1:0] {
    KEY_128  = 2'b00,
    KEY_192  = 2'b01,
    KEY_256  = 2'b10,
    KEY_RSVD = 2'b11
  } key_len_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [3:0] nk(input key_len_e kl);
    case (kl)
      KEY_192: return 4'd6;
      KEY_256: return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr(input key_len_e kl);
    case (kl)
      KEY_192: return 4'd12;
      KEY_256: return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  // Table offset of entry b is 2047 - 8*b, i.e. {~b, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // Substitute each byte independently.
  always_comb begin
    dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};
  end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key schedule. Generates one schedule word per
// cycle into a 4-word assembly register and streams 128-bit round keys
// through an output register with valid/ready backpressure.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              key_len,
  input  logic [MAX_KEY_BITS-1:0] key_in,
  output logic                    busy,
  output logic                    err,
  output logic                    rk_valid,
  input  logic                    rk_ready,
  output logic [127:0]            rk_data,
  output logic [3:0]              rk_idx,
  output logic                    rk_last
);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_DRAIN} state_e;

  state_e       state;
  key_len_e     klen;
  logic [31:0]  win [8];
  logic [127:0] asm_data;
  logic [2:0]   asm_cnt;
  logic [3:0]   asm_idx;
  logic [5:0]   word_cnt;
  logic [2:0]   phase;
  logic [7:0]   rcon;

  logic [3:0]   cur_nk, cur_nr, nk_in;
  logic         key_ok, accept;
  logic         asm_full, out_free, xfer, gen_en, last_word, key_phase;
  logic [31:0]  sub_in, sub_out, t_word, new_word;
  logic [255:0] key_full;
  logic [31:0]  key_word [8];

  assign cur_nk = nk(klen);
  assign cur_nr = nr(klen);
  assign nk_in  = nk(key_len_e'(key_len));
  assign key_ok = (key_len != 2'b11) && (int'(nk_in) * 32 <= MAX_KEY_BITS);
  assign accept = (state == S_IDLE) && start && key_ok;

  assign asm_full  = (asm_cnt == 3'd4);
  assign out_free  = !rk_valid || rk_ready;
  assign xfer      = (state != S_IDLE) && asm_full && out_free;
  assign gen_en    = (state == S_GEN) && !(asm_full && !out_free);
  assign last_word = (word_cnt == {cur_nr, 2'b11});
  assign key_phase = (word_cnt < {2'b00, cur_nk});

  // Left-justify the key into 256 bits and split into words, word 0 first.
  always_comb begin
    key_full = '0;
    key_full[255 -: MAX_KEY_BITS] = key_in;
    for (int j = 0; j < 8; j++) key_word[j] = key_full[255 - 32*j -: 32];
  end

  // The RotWord path and the Nk=8 mid-block path never coincide, so one
  // S-box word serves both.
  assign sub_in = (phase == 3'd0) ? {win[0][23:0], win[0][31:24]} : win[0];

  aes_sbox_word u_sbox (
    .din  (sub_in),
    .dout (sub_out)
  );

  // Select the recurrence term t from w[i-1]; during the key words the
  // window simply rotates the loaded key out through its oldest slot.
  always_comb begin
    t_word = win[0];
    if (phase == 3'd0)
      t_word = sub_out ^ {rcon, 24'h0};
    else if (cur_nk == 4'd8 && phase == 3'd4)
      t_word = sub_out;
    new_word = win[3'(cur_nk - 4'd1)] ^ (key_phase ? 32'h0 : t_word);
  end

  // Word window and assembly shift register; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 8; k++)
        win[k] <= (k < int'(nk_in)) ? key_word[3'(int'(nk_in) - 1 - k)] : 32'h0;
    end else if (gen_en) begin
      win[0] <= new_word;
      for (int k = 1; k < 8; k++) win[k] <= win[k-1];
      asm_data <= {asm_data[95:0], new_word};
    end
  end

  // Control FSM, counters, rcon and the registered round-key output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      klen     <= KEY_128;
      busy     <= 1'b0;
      err      <= 1'b0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_idx   <= '0;
      rk_last  <= 1'b0;
      asm_cnt  <= '0;
      asm_idx  <= '0;
      word_cnt <= '0;
      phase    <= '0;
      rcon     <= RCON_INIT;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (key_ok) begin
              state    <= S_GEN;
              klen     <= key_len_e'(key_len);
              busy     <= 1'b1;
              word_cnt <= '0;
              phase    <= '0;
              rcon     <= RCON_INIT;
              asm_cnt  <= '0;
              asm_idx  <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_GEN: begin
          if (gen_en) begin
            word_cnt <= word_cnt + 6'd1;
            phase    <= (phase == 3'(cur_nk - 4'd1)) ? 3'd0 : phase + 3'd1;
            if (phase == 3'd0 && !key_phase) rcon <= xtime(rcon);
            if (last_word) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (rk_valid && rk_ready && rk_last) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (state != S_IDLE) begin
        if (xfer) begin
          asm_cnt <= gen_en ? 3'd1 : 3'd0;
          asm_idx <= asm_idx + 4'd1;
        end else if (gen_en) begin
          asm_cnt <= asm_cnt + 3'd1;
        end
      end

      if (xfer) begin
        rk_valid <= 1'b1;
        rk_data  <= asm_data;
        rk_idx   <= asm_idx;
        rk_last  <= (asm_idx == cur_nr);
      end else if (rk_valid && rk_ready) begin
        rk_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: FIPS-197 key vectors in a table,
// plus backpressure, rejected/ignored start and mid-run reset sequences.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'b00;
  logic [255:0] key_in = '0;
  logic         rk_ready = 1'b0;
  logic         busy, err, rk_valid, rk_last;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;

  aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_len  (key_len),
    .key_in   (key_in),
    .busy     (busy),
    .err      (err),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_idx   (rk_idx),
    .rk_last  (rk_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   kl;
    logic [255:0] key;
    int           nr;
    logic [127:0] rk0;
    logic [127:0] rk1;
    logic [127:0] rk1_mask;
    logic [127:0] rk_fin;
  } vec_t;

  int total = 0;
  int bad = 0;

  logic [127:0] got_data [16];
  logic [3:0]   got_idx  [16];
  logic         got_last [16];
  int           got_cyc  [16];
  int           ngot;

  logic [127:0] exp128 [11];
  vec_t         vecs [3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one schedule and collect round keys until nr+1 handshakes,
  // stop_after handshakes, or the cycle budget runs out.
  task automatic run_schedule(input logic [1:0] kl, input logic [255:0] key, input int nr,
                              input bit random_ready, input bit second_start, input int stop_after);
    int           cyc;
    int           want;
    bit           holding;
    logic [127:0] hold_data;
    logic [3:0]   hold_idx;
    ngot = 0;
    holding = 1'b0;
    hold_data = '0;
    hold_idx = '0;
    key_len = kl;
    key_in = key;
    start = 1'b1;
    rk_ready = 1'b1;
    tick();
    start = 1'b0;
    key_in = ~key;
    key_len = 2'b11;
    cyc = 0;
    want = (nr + 1 < stop_after) ? nr + 1 : stop_after;
    while (ngot < want && cyc < 600) begin
      if (holding) begin
        check("stall_valid", 128'(rk_valid), 128'(1));
        check("stall_data", rk_data, hold_data);
        check("stall_idx", 128'(rk_idx), 128'(hold_idx));
        holding = 1'b0;
      end
      if (second_start && cyc == 11) check("ignored_start_err", 128'(err), 128'(0));
      if (second_start && cyc == 10) begin
        start = 1'b1;
        key_len = 2'b01;
        key_in = {256{1'b1}};
      end else begin
        start = 1'b0;
      end
      if (random_ready)
        rk_ready = (cyc >= 12 && cyc < 32) ? 1'b0 : ($urandom_range(0, 2) != 0);
      else
        rk_ready = 1'b1;
      if (rk_valid && rk_ready) begin
        got_data[ngot] = rk_data;
        got_idx[ngot]  = rk_idx;
        got_last[ngot] = rk_last;
        got_cyc[ngot]  = cyc;
        ngot++;
      end else if (rk_valid) begin
        holding = 1'b1;
        hold_data = rk_data;
        hold_idx = rk_idx;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    rk_ready = 1'b1;
    check("handshake_count", 128'(ngot), 128'(want));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp128[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    vecs[0] = '{kl: 2'b00,
                key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdeffedcba9876543210},
                nr: 10,
                rk0: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                rk1: 128'ha0fafe1788542cb123a339392a6c7605,
                rk1_mask: {128{1'b1}},
                rk_fin: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{kl: 2'b01,
                key: {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hdeadbeefcafef00d},
                nr: 12,
                rk0: 128'h8e73b0f7da0e6452c810f32b809079e5,
                rk1: {64'h62f8ead2522c6b7b, 64'h0},
                rk1_mask: {{64{1'b1}}, 64'h0},
                rk_fin: 128'he98ba06f448c773c8ecc720401002202};
    vecs[2] = '{kl: 2'b10,
                key: 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                nr: 14,
                rk0: 128'h603deb1015ca71be2b73aef0857d7781,
                rk1: 128'h1f352c073b6108d72d9810a30914dff4,
                rk1_mask: {128{1'b1}},
                rk_fin: 128'hfe4890d1e6188d0b046df344706c631e};

    // Reset values while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_valid", 128'(rk_valid), 128'(0));
    check("rst_data", rk_data, 128'h0);
    check("rst_idx", 128'(rk_idx), 128'(0));
    check("rst_last", 128'(rk_last), 128'(0));
    rst_n = 1'b1;
    tick();

    // Table vectors with rk_ready held high.
    for (int v = 0; v < 3; v++) begin
      run_schedule(vecs[v].kl, vecs[v].key, vecs[v].nr, 1'b0, 1'b0, 99);
      check($sformatf("v%0d_rk0", v), got_data[0], vecs[v].rk0);
      check($sformatf("v%0d_rk1", v), got_data[1] & vecs[v].rk1_mask, vecs[v].rk1);
      check($sformatf("v%0d_rkfin", v), got_data[vecs[v].nr], vecs[v].rk_fin);
      check($sformatf("v%0d_first_cyc", v), 128'(got_cyc[0]), 128'(5));
      check($sformatf("v%0d_last_cyc", v), 128'(got_cyc[vecs[v].nr]), 128'(5 + 4 * vecs[v].nr));
      for (int k = 0; k <= vecs[v].nr; k++) begin
        check($sformatf("v%0d_idx%0d", v, k), 128'(got_idx[k]), 128'(k));
        check($sformatf("v%0d_last%0d", v, k), 128'(got_last[k]), 128'(k == vecs[v].nr));
      end
      if (v == 0)
        for (int k = 0; k < 11; k++) check($sformatf("aes128_rk%0d", k), got_data[k], exp128[k]);
      check($sformatf("v%0d_busy_end", v), 128'(busy), 128'(0));
      check($sformatf("v%0d_valid_end", v), 128'(rk_valid), 128'(0));
      tick();
    end

    // AES-128 under random backpressure with a 20-cycle stall and an
    // extra start while busy.
    run_schedule(2'b00, vecs[0].key, 10, 1'b1, 1'b1, 99);
    for (int k = 0; k < 11; k++) check($sformatf("bp_rk%0d", k), got_data[k], exp128[k]);
    check("bp_last", 128'(got_last[10]), 128'(1));
    check("bp_busy_end", 128'(busy), 128'(0));
    tick();

    // Illegal key_len: one-cycle err pulse, no run started.
    key_len = 2'b11;
    key_in = vecs[2].key;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_pulse", 128'(err), 128'(1));
    check("err_busy", 128'(busy), 128'(0));
    tick();
    check("err_clear", 128'(err), 128'(0));
    check("err_busy2", 128'(busy), 128'(0));
    check("err_valid", 128'(rk_valid), 128'(0));

    // Reset after the rk4 handshake, then a full AES-256 run.
    run_schedule(2'b00, vecs[0].key, 10, 1'b0, 1'b0, 5);
    check("pre_rst_busy", 128'(busy), 128'(1));
    check("pre_rst_rk4", got_data[4], exp128[4]);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(rk_valid), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_data", rk_data, 128'h0);
    #3;
    rst_n = 1'b1;
    tick();
    run_schedule(2'b10, vecs[2].key, 14, 1'b0, 1'b0, 99);
    check("post_rst_rk0", got_data[0], vecs[2].rk0);
    check("post_rst_rk1", got_data[1], vecs[2].rk1);
    check("post_rst_rk14", got_data[14], vecs[2].rk_fin);
    check("post_rst_idx14", 128'(got_idx[14]), 128'(14));
    check("post_rst_last", 128'(got_last[14]), 128'(1));
    check("post_rst_first_cyc", 128'(got_cyc[0]), 128'(5));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative AES key-schedule generator for 128-, 192- and 256-bit keys, selected per run. It streams round keys 0..Nr as 128-bit words over a valid/ready handshake, producing one 32-bit schedule word per cycle. It replaces the single-round combinational expansion step in the cipher datapath: the cipher core consumes round keys in order, with backpressure.

## Interface
- MAX_KEY_BITS, default 256: widest supported key; legal values 128, 192, 256. Sets key_in width. Key lengths above it are rejected.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new schedule; accepted only when busy=0.
- key_len  in  2  2'b00=128 (Nk=4, Nr=10), 2'b01=192 (Nk=6, Nr=12), 2'b10=256 (Nk=8, Nr=14), 2'b11 reserved.
- key_in  in  MAX_KEY_BITS  cipher key, left-justified (word 0 at MSBs); sampled only on accepted start.
- busy  out  1  high from accepted start until the last round-key handshake completes.
- err  out  1  one-cycle pulse when start is rejected for an illegal key_len.
- rk_valid  out  1  rk_data/rk_idx/rk_last valid.
- rk_ready  in  1  consumer accepts the round key when rk_valid & rk_ready.
- rk_data  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- rk_idx  out  4  round index r, 0..Nr.
- rk_last  out  1  high with rk_idx==Nr.

## Operation
- Word recurrence, i = 0..4(Nr+1)-1:
  - i<Nk: w[i] = key word i.
  - Otherwise t = w[i-1].
  - If i mod Nk==0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}.
  - Else if Nk==8 and i mod 8==4: t = SubWord(t).
  - w[i] = w[i-Nk] ^ t.
- rcon register: starts at 8'h01 and advances by xtime (wrapping 8'h80 to 8'h1b) after each i mod Nk==0 word. No divider; i mod Nk comes from a wrapping phase counter.
- Storage:
  - sliding window of the last Nk words (8-word shift register);
  - 4-word assembly register;
  - 128-bit output register.
- States:
  - IDLE: start & legal → latch key_in, key_len; clear counters; → GEN. Illegal key_len → err=1, stay IDLE.
  - GEN: append one word per cycle to assembly unless stalled. A full assembly transfers to the output register when the output is empty or handshaking. Stall when the assembly is full and cannot transfer. After word 4(Nr+1)-1 → DRAIN.
  - DRAIN: wait for the remaining assembly and output contents to hand off. Final handshake (rk_last) → IDLE, busy=0 on the next cycle.
- rk_data, rk_idx and rk_last stay stable while rk_valid & !rk_ready.
- start, key_in and key_len are ignored while busy=1.
- A key_len that is legal but exceeds MAX_KEY_BITS (e.g. 2'b10 with MAX_KEY_BITS=128) is rejected like 2'b11.
- A 192-bit key in a 256-bit port uses key_in[255:64]; the low bits are ignored.

## Timing
- Reset (asynchronous assert, synchronous release): busy=0, err=0, rk_valid=0, rk_data=0, rk_idx=0, rk_last=0, state IDLE, rcon=8'h01.
- Reset mid-run abandons the schedule; no partial key is ever presented.
- Start accepted at edge E0: w0..w3 written at E1..E4; rk0 valid after E5.
- With rk_ready held high, round key r is valid after E5+4r. The last key is valid after E45/E53/E61 for 128/192/256, and busy falls one cycle after its handshake.
- Throughput: one round key per 4 cycles. With rk_ready low, at most 2 round keys are buffered (assembly + output); word generation freezes and the window, rcon and counters hold.
- err is asserted for exactly the cycle after the rejected start edge.
- start arriving in the same cycle that busy falls is ignored. start is accepted only when busy=0 is sampled.

## Structure
- Package aes_pkg:
  - key_len enum;
  - nk(key_len) and nr(key_len) functions;
  - S-box table constant;
  - xtime function;
  - RCON_INIT=8'h01.
- Sub-module aes_sbox_word: combinational, 32-bit in/out, four S-box lookups. One instance is shared by the RotWord path and the Nk==8 i mod 8==4 path; the two are mutually exclusive.
- Remainder (FSM, window, counters, buffers) lives in aes_key_schedule.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 → rk0 equals the key; rk10=d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1 after E45.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → rk12=e98ba06f448c773c8ecc720401002202, rk_idx=12.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → rk14=fe4890d1e6188d0b046df344706c631e.
- AES-128 vector with random rk_ready backpressure (including 20-cycle stalls) → identical key sequence; outputs stable while stalled; 11 handshakes total.
- key_len=2'b11 start → err pulse for one cycle, busy stays 0. Second start while busy → ignored, sequence unchanged.
- rst_n asserted after the rk4 handshake → rk_valid=0 and busy=0 immediately. A new AES-256 start after release → correct full sequence.
